// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter sharing one UART byte transmitter
// A grant is held from the first byte of a packet until its last byte or a hold timeout.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     pkt_active,
  output logic                     timeout_pulse
);
  localparam int GW = $clog2(N_REQ);
  localparam int HW = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_IDX  = GW'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic            last_q;
  logic [HW-1:0]   hold_cnt;

  logic [7:0]      req_byte [N_REQ];
  logic [GW:0]     cand;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   next_ptr;
  logic [GW-1:0]   load_id;
  logic [N_REQ-1:0] load_onehot;
  logic            gnt_valid;
  logic            do_load;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_byte[g] = req_data[8*g +: 8];
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    winner = rr_ptr;
    cand   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (GW+1)'(i);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (req_valid[cand[GW-1:0]]) winner = cand[GW-1:0];
    end
  end

  always_comb begin
    next_ptr  = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
    gnt_valid = req_valid[grant_id];
    load_id   = (state == IDLE) ? winner : grant_id;
    do_load   = 1'b0;
    case (state)
      IDLE:      do_load = (|req_valid) && !tx_busy;
      WAIT_DONE: do_load = !tx_busy && !last_q && gnt_valid;
      HOLD:      do_load = gnt_valid && !tx_busy;
      default:   do_load = 1'b0;
    endcase
  end

  assign load_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << load_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      last_q        <= 1'b0;
      hold_cnt      <= '0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      req_ready     <= '0;
      grant_id      <= '0;
      pkt_active    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      tx_start      <= 1'b0;
      req_ready     <= '0;
      timeout_pulse <= 1'b0;
      if (do_load) begin
        state      <= LOAD;
        grant_id   <= load_id;
        tx_data    <= req_byte[load_id];
        last_q     <= req_last[load_id];
        tx_start   <= 1'b1;
        req_ready  <= load_onehot;
        pkt_active <= 1'b1;
      end else begin
        case (state)
          LOAD:      state <= WAIT_BUSY;
          WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
          WAIT_DONE: begin
            if (!tx_busy) begin
              if (last_q) begin
                state      <= IDLE;
                pkt_active <= 1'b0;
                rr_ptr     <= next_ptr;
              end else begin
                state    <= HOLD;
                hold_cnt <= '0;
              end
            end
          end
          HOLD: begin
            // A valid byte held off only by external busy keeps the lock alive.
            if (!gnt_valid) begin
              if (hold_cnt == HOLD_LAST) begin
                timeout_pulse <= 1'b1;
                pkt_active    <= 1'b0;
                rr_ptr        <= next_ptr;
                state         <= IDLE;
              end else if (hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
